// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg : shared constants and write-request type for writeback |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
package regfile_pkg;
  localparam int REG_ZERO   = 31;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  // Widest data path a write request can carry; DATA_W of any user must not exceed it.
  localparam int WB_DATA_W  = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_req_t;
endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_fifo  : MEM_DEPTH-entry FIFO of register write requests          |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int PTR_W = $clog2(MEM_DEPTH);

  if (DATA_W > WB_DATA_W || DATA_W < 1) begin : g_width_check
    $error("wb_fifo: DATA_W out of range");
  end
  if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_depth_check
    $error("wb_fifo: MEM_DEPTH must be a power of two >= 2");
  end

  wb_req_t          mem_q [MEM_DEPTH];
  wb_req_t          mem_d [MEM_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // The extra top pointer bit tells a full FIFO from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_req;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_writeback : ALU/memory write arbitration, scoreboard, RF port   |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
module reg_writeback
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic                  issue_ready,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [4:0]            mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [4:0]            WriteRegister,
  output logic [DATA_W-1:0]     WriteData,
  output logic                  RegWrite,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [NUM_REGS-1:0]   busy
);
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_register_q, write_register_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;

  logic    fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_req_t fifo_head, mem_req, win_req;
  logic    win_valid, issue_set;

  assign mem_ready = !fifo_full;
  assign fifo_push = mem_valid && mem_ready;
  assign mem_req   = '{rd: mem_rd, data: WB_DATA_W'(mem_data)};

  wb_fifo #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_req (mem_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A full FIFO pre-empts the ALU so memory results can never starve.
  always_comb begin
    alu_ready = 1'b1;
    fifo_pop  = 1'b0;
    win_valid = 1'b0;
    win_req   = fifo_head;
    if (fifo_full && !fifo_empty) begin
      alu_ready = 1'b0;
      fifo_pop  = 1'b1;
      win_valid = 1'b1;
    end else if (alu_valid) begin
      win_valid = 1'b1;
      win_req   = '{rd: alu_rd, data: WB_DATA_W'(alu_data)};
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      win_valid = 1'b1;
    end
  end

  assign issue_ready = !(issue_valid && issue_rd != ZERO_ADDR && busy_q[issue_rd]);
  assign issue_set   = issue_valid && issue_ready && issue_rd != ZERO_ADDR;

  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[write_register_q] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;

    reg_write_d      = win_valid && (win_req.rd != ZERO_ADDR);
    write_register_d = reg_write_d ? win_req.rd : write_register_q;
    write_data_d     = reg_write_d ? win_req.data[DATA_W-1:0] : write_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q           <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      busy_q           <= busy_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  assign busy          = busy_q;
  assign RegWrite      = reg_write_q;
  assign WriteRegister = write_register_q;
  assign WriteData     = write_data_q;

  // The register being written this cycle is not yet visible in the register file.
  assign hazard1 = busy_q[ReadRegister1] ||
                   (reg_write_q && write_register_q == ReadRegister1 && ReadRegister1 != ZERO_ADDR);
  assign hazard2 = busy_q[ReadRegister2] ||
                   (reg_write_q && write_register_q == ReadRegister2 && ReadRegister2 != ZERO_ADDR);
endmodule
`default_nettype wire
